// File: rtl/tinymips_pkg.sv
// Shared definitions for the TinyMIPS memory responder: MMIO offsets measured down from the
// top of the word map, sequencer state encoding and OUT_STAT bit layout.
package tinymips_pkg;

    // MMIO register address = 2**SIZE - offset
    localparam int unsigned CYC_LO_OFS   = 8;
    localparam int unsigned CYC_HI_OFS   = 7;
    localparam int unsigned OUT_DATA_OFS = 6;
    localparam int unsigned OUT_STAT_OFS = 5;
    localparam int unsigned HALT_OFS     = 4;

    // Number of words at the top of the map that are not RAM
    localparam int unsigned MMIO_WORDS = 8;

    // OUT_STAT read layout
    localparam int unsigned STAT_OVF_BIT   = 15;
    localparam int unsigned STAT_FULL_BIT  = 14;
    localparam int unsigned STAT_EMPTY_BIT = 13;
    localparam int unsigned STAT_CNT_W     = 8;

    typedef enum logic [1:0] {
        StLoad    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } seqState_t;

endpackage

// File: rtl/resp_outq.sv
// Synchronous output FIFO; pointers carry one extra wrap bit so full and empty are distinct.
module resp_outq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush;
    logic             doPop;

    assign count  = wrPtr - rdPtr;
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue is still accepted
    assign doPush = push && (!full || doPop);
    assign rdData = empty ? '0 : mem[rdPtr[AW-1:0]];

    // Pointer update; flush empties the queue and overrides any push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr[AW-1:0]] <= wrData;
    end

endmodule

// File: rtl/tinymips_mem_responder.sv
// Memory-side responder for the TinyMIPS core: word RAM, MMIO window (cycle counter, output
// FIFO, halt flag), host program-load port and CPU reset sequencer.
module tinymips_mem_responder
    import tinymips_pkg::*;
#(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned OUTQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [SIZE-1:0] addr,
    input  logic [15:0]     din,
    output logic [15:0]     dout,
    output logic            cpu_rst,
    input  logic            ld_en,
    input  logic            ld_we,
    input  logic [SIZE-1:0] ld_addr,
    input  logic [15:0]     ld_data,
    output logic            out_valid,
    output logic [15:0]     out_data,
    input  logic            out_ready,
    output logic            halted
);
    localparam int unsigned TOP       = 2 ** SIZE;
    localparam int unsigned RAM_WORDS = TOP - MMIO_WORDS;
    localparam int unsigned CNT_W     = $clog2(OUTQ_DEPTH) + 1;

    localparam int unsigned CYC_LO_I   = TOP - CYC_LO_OFS;
    localparam int unsigned CYC_HI_I   = TOP - CYC_HI_OFS;
    localparam int unsigned OUT_DATA_I = TOP - OUT_DATA_OFS;
    localparam int unsigned OUT_STAT_I = TOP - OUT_STAT_OFS;
    localparam int unsigned HALT_I     = TOP - HALT_OFS;

    localparam logic [SIZE-1:0] RAM_END    = RAM_WORDS[SIZE-1:0];
    localparam logic [SIZE-1:0] A_CYC_LO   = CYC_LO_I[SIZE-1:0];
    localparam logic [SIZE-1:0] A_CYC_HI   = CYC_HI_I[SIZE-1:0];
    localparam logic [SIZE-1:0] A_OUT_DATA = OUT_DATA_I[SIZE-1:0];
    localparam logic [SIZE-1:0] A_OUT_STAT = OUT_STAT_I[SIZE-1:0];
    localparam logic [SIZE-1:0] A_HALT     = HALT_I[SIZE-1:0];

    seqState_t        state;
    logic             relCnt;
    logic             inLoad;
    logic             inRun;
    logic             isRam;
    logic             ramWe;
    logic [SIZE-1:0]  ramAddr;
    logic [15:0]      ramWData;
    logic [15:0]      ram [RAM_WORDS];
    logic [31:0]      cycCnt;
    logic [15:0]      shadow;
    logic             ovf;
    logic             pushReq;
    logic             popReq;
    logic             drop;
    logic             qFull;
    logic             qEmpty;
    logic [CNT_W-1:0] qCount;
    logic [15:0]      statWord;
    logic [15:0]      rdData;

    assign inLoad    = (state == StLoad);
    assign inRun     = (state == StRun);
    assign isRam     = (addr < RAM_END);
    assign pushReq   = inRun && we && (addr == A_OUT_DATA);
    assign popReq    = out_ready && !qEmpty;
    assign drop      = pushReq && qFull && !popReq;
    assign out_valid = !qEmpty;

    // Sequencer: LOAD holds the core in reset, RELEASE stretches reset for two cycles, RUN frees it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StRelease;
            relCnt  <= 1'b0;
            cpu_rst <= 1'b1;
        end else begin
            case (state)
                StLoad: begin
                    if (!ld_en) begin
                        state  <= StRelease;
                        relCnt <= 1'b0;
                    end
                end
                StRelease: begin
                    if (ld_en) begin
                        state <= StLoad;
                    end else if (relCnt) begin
                        state   <= StRun;
                        cpu_rst <= 1'b0;
                    end else begin
                        relCnt <= 1'b1;
                    end
                end
                StRun: begin
                    if (ld_en) begin
                        state   <= StLoad;
                        cpu_rst <= 1'b1;
                    end
                end
                default: begin
                    state   <= StRelease;
                    relCnt  <= 1'b0;
                    cpu_rst <= 1'b1;
                end
            endcase
        end
    end

    // RAM write port is owned by the host while loading and by the core while running
    always_comb begin
        ramWe    = 1'b0;
        ramAddr  = addr;
        ramWData = din;
        if (inLoad) begin
            ramWe    = ld_we && (ld_addr < RAM_END);
            ramAddr  = ld_addr;
            ramWData = ld_data;
        end else if (inRun) begin
            ramWe = we && isRam;
        end
    end

    // RAM storage; not reset so a program survives rst
    always_ff @(posedge clk) begin
        if (ramWe) ram[ramAddr] <= ramWData;
    end

    resp_outq #(
        .DEPTH (OUTQ_DEPTH),
        .WIDTH (16)
    ) u_outq (
        .clk    (clk),
        .rst    (rst),
        .flush  (inLoad),
        .push   (pushReq),
        .pop    (popReq),
        .wrData (din),
        .rdData (out_data),
        .full   (qFull),
        .empty  (qEmpty),
        .count  (qCount)
    );

    // Read mux; RAM value is sampled before this edge's write, giving read-first behaviour
    always_comb begin
        statWord                   = '0;
        statWord[STAT_OVF_BIT]     = ovf;
        statWord[STAT_FULL_BIT]    = qFull;
        statWord[STAT_EMPTY_BIT]   = qEmpty;
        statWord[STAT_CNT_W-1:0]   = STAT_CNT_W'(qCount);
        rdData                     = '0;
        if (isRam) begin
            rdData = ram[addr];
        end else begin
            case (addr)
                A_CYC_LO:   rdData = cycCnt[15:0];
                A_CYC_HI:   rdData = shadow;
                A_OUT_STAT: rdData = statWord;
                default:    rdData = '0;
            endcase
        end
    end

    // Registered read data, cycle counter, shadow, halt and overflow flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycCnt <= '0;
            shadow <= '0;
            halted <= 1'b0;
            ovf    <= 1'b0;
            dout   <= '0;
        end else if (inLoad) begin
            cycCnt <= '0;
            halted <= 1'b0;
            ovf    <= 1'b0;
        end else if (inRun) begin
            if (!halted) cycCnt <= cycCnt + 32'd1;
            dout <= rdData;
            if (addr == A_CYC_LO) shadow <= cycCnt[31:16];
            if (we && (addr == A_HALT) && (din != 16'd0)) halted <= 1'b1;
            if (we && (addr == A_OUT_STAT)) begin
                ovf <= 1'b0;
            end else if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tinymips_mem_responder.sv
// Self-checking bench: a queue/array model of the responder predicts every output each cycle,
// and literal expectations at key points pin the model itself.
module tb_tinymips_mem_responder;
    localparam int unsigned SIZE  = 8;
    localparam int unsigned DEPTH = 4;
    localparam int          TOP   = 256;
    localparam int          RAMW  = TOP - 8;

    localparam logic [7:0] A_CYC_LO   = 8'd248;
    localparam logic [7:0] A_CYC_HI   = 8'd249;
    localparam logic [7:0] A_OUT_DATA = 8'd250;
    localparam logic [7:0] A_OUT_STAT = 8'd251;
    localparam logic [7:0] A_HALT     = 8'd252;

    logic        clk;
    logic        rst;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        cpu_rst;
    logic        ld_en;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        halted;

    tinymips_mem_responder #(
        .SIZE       (SIZE),
        .OUTQ_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .cpu_rst   (cpu_rst),
        .ld_en     (ld_en),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nVec = 0;
    int nErr = 0;
    bit checkEn = 1'b0;

    // Behavioural model state, always holding the values expected after the next edge
    logic [15:0] mMem [RAMW];
    logic [31:0] mCyc;
    logic [15:0] mShadow;
    logic [15:0] mDout;
    bit          mHalted;
    bit          mOvf;
    bit          mLoading;
    int          mRelLeft;
    logic [15:0] mQ [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCyc     = '0;
        mShadow  = '0;
        mDout    = '0;
        mHalted  = 1'b0;
        mOvf     = 1'b0;
        mLoading = 1'b0;
        mRelLeft = 2;
        mQ.delete();
    endtask

    // Predict the effect of the coming rising edge from the current inputs
    task automatic modelStep();
        bit          pop;
        bit          oldHalted;
        int          a;
        int          qn;
        logic [15:0] rd;
        if (rst) begin
            modelReset();
            return;
        end
        pop = out_ready && (mQ.size() != 0);
        if (mLoading) begin
            if (ld_we && (int'(ld_addr) < RAMW)) mMem[ld_addr] = ld_data;
            mCyc    = '0;
            mHalted = 1'b0;
            mOvf    = 1'b0;
            mQ.delete();
            if (!ld_en) begin
                mLoading = 1'b0;
                mRelLeft = 2;
            end
        end else if (mRelLeft > 0) begin
            if (pop) void'(mQ.pop_front());
            if (ld_en) mLoading = 1'b1;
            else       mRelLeft--;
        end else begin
            a         = int'(addr);
            qn        = mQ.size();
            oldHalted = mHalted;
            rd        = '0;
            if (a < RAMW) begin
                rd = mMem[a];
            end else begin
                case (TOP - a)
                    8: begin
                        rd      = mCyc[15:0];
                        mShadow = mCyc[31:16];
                    end
                    7:       rd = mShadow;
                    5:       rd = {mOvf, qn == DEPTH, qn == 0, 5'b0, 8'(qn)};
                    default: rd = '0;
                endcase
            end
            mDout = rd;
            if (pop) void'(mQ.pop_front());
            if (we) begin
                if (a < RAMW) begin
                    mMem[a] = din;
                end else begin
                    case (TOP - a)
                        6: begin
                            if ((qn < DEPTH) || pop) mQ.push_back(din);
                            else                     mOvf = 1'b1;
                        end
                        5:       mOvf = 1'b0;
                        4:       if (din != 16'd0) mHalted = 1'b1;
                        default: ;
                    endcase
                end
            end
            if (!oldHalted) mCyc = mCyc + 32'd1;
            if (ld_en) mLoading = 1'b1;
        end
    endtask

    // Per-cycle comparison against the model, just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (checkEn) begin
                check("dout", 32'(dout), 32'(mDout));
                check("cpu_rst", 32'(cpu_rst), 32'(mLoading || (mRelLeft > 0)));
                check("out_valid", 32'(out_valid), 32'(mQ.size() != 0));
                check("out_data", 32'(out_data), (mQ.size() != 0) ? 32'(mQ[0]) : 32'h0);
                check("halted", 32'(halted), 32'(mHalted));
            end
        end
    end

    task automatic tick();
        modelStep();
        @(posedge clk);
        #2;
    endtask

    task automatic cpuRead(input logic [7:0] a);
        we   = 1'b0;
        addr = a;
        tick();
    endtask

    task automatic cpuWrite(input logic [7:0] a, input logic [15:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        tick();
        we   = 1'b0;
    endtask

    task automatic releaseLoad();
        ld_en = 1'b0;
        ld_we = 1'b0;
        we    = 1'b0;
        tick();
        tick();
        tick();
        check("release_cpu_rst", 32'(cpu_rst), 32'h0);
    endtask

    task automatic settleRun();
        int guard;
        ld_en = 1'b0;
        ld_we = 1'b0;
        guard = 0;
        while ((mLoading || (mRelLeft > 0)) && (guard < 10)) begin
            tick();
            guard++;
        end
    endtask

    initial begin
        int guard;
        int ldHold;
        rst = 1'b1; we = 1'b0; addr = '0; din = '0;
        ld_en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b0;
        modelReset();
        @(posedge clk);
        #2;
        check("rst_cpu_rst", 32'(cpu_rst), 32'h1);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        checkEn = 1'b1;
        rst = 1'b0;

        // Two cycles of reset hold after rst falls
        tick();
        check("post_rst_cycle1", 32'(cpu_rst), 32'h1);
        tick();
        check("post_rst_cycle2", 32'(cpu_rst), 32'h0);
        check("post_rst_dout", 32'(dout), 32'h0);

        // Load the whole RAM while the CPU port carries ignored noise
        ld_en = 1'b1;
        tick();
        check("load_entry_cpu_rst", 32'(cpu_rst), 32'h1);
        for (int i = 0; i < RAMW; i++) begin
            ld_we   = 1'b1;
            ld_addr = 8'(i);
            ld_data = 16'($urandom);
            we      = 1'($urandom);
            addr    = 8'($urandom);
            din     = 16'($urandom);
            tick();
        end
        ld_addr = 8'd0;  ld_data = 16'h7205; tick();
        ld_addr = 8'd15; ld_data = 16'h0005; tick();
        releaseLoad();

        // Read-first RAM behaviour
        cpuRead(8'd15);
        check("ram_read_15", 32'(dout), 32'h0005);
        cpuWrite(8'd15, 16'h1234);
        check("ram_read_first", 32'(dout), 32'h0005);
        cpuRead(8'd15);
        check("ram_read_new", 32'(dout), 32'h1234);

        // Counter after 100 idle cycles: 3 RUN cycles already elapsed
        for (int i = 0; i < 100; i++) cpuRead(8'($urandom_range(0, 31)));
        cpuRead(A_CYC_LO);
        check("cyc_lo_103", 32'(dout), 32'd103);
        cpuRead(A_CYC_HI);
        check("cyc_hi_0", 32'(dout), 32'h0);

        // Run the counter to 0x0000FFFF and read across the 16-bit rollover
        guard = 0;
        while ((mCyc != 32'h0000FFFF) && (guard < 70000)) begin
            cpuRead(8'($urandom_range(0, 31)));
            guard++;
        end
        if (guard >= 70000) begin
            nVec++;
            nErr++;
            $display("FAIL cyc_wait: counter 0x%0h never reached 0xffff", mCyc);
        end
        cpuRead(A_CYC_LO);
        check("roll_lo", 32'(dout), 32'hFFFF);
        cpuRead(A_CYC_HI);
        check("roll_hi_shadow", 32'(dout), 32'h0000);
        cpuRead(A_CYC_LO);
        check("roll_lo2", 32'(dout), 32'h0001);
        cpuRead(A_CYC_HI);
        check("roll_hi2", 32'(dout), 32'h0001);

        // FIFO overflow: six pushes into depth 4
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) cpuWrite(A_OUT_DATA, 16'(i));
        cpuRead(A_OUT_STAT);
        check("stat_full_ovf", 32'(dout), 32'hC004);
        cpuRead(A_OUT_DATA);
        check("out_data_read_zero", 32'(dout), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            check("fifo_head", 32'(out_data), 32'(i));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("fifo_drained", 32'(out_valid), 32'h0);
        cpuRead(A_OUT_STAT);
        check("stat_empty_ovf", 32'(dout), 32'hA000);
        cpuWrite(A_OUT_STAT, 16'h0000);
        cpuRead(A_OUT_STAT);
        check("stat_ovf_cleared", 32'(dout), 32'h2000);

        // Push and pop together on a full FIFO
        for (int i = 10; i <= 13; i++) cpuWrite(A_OUT_DATA, 16'(i));
        out_ready = 1'b1;
        cpuWrite(A_OUT_DATA, 16'd14);
        out_ready = 1'b0;
        cpuRead(A_OUT_STAT);
        check("stat_full_no_ovf", 32'(dout), 32'h4004);
        check("fifo_head_11", 32'(out_data), 32'd11);

        // Randomized traffic including occasional load aborts
        ldHold = 0;
        for (int i = 0; i < 3000; i++) begin
            we        = 1'($urandom);
            addr      = $urandom_range(0, 1) ? 8'($urandom_range(248, 255))
                                             : 8'($urandom_range(0, 31));
            din       = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            out_ready = 1'($urandom);
            ld_we     = 1'($urandom);
            ld_addr   = 8'($urandom_range(0, 40));
            ld_data   = 16'($urandom);
            if (ldHold > 0) begin
                ld_en = 1'b1;
                ldHold--;
            end else begin
                ld_en = 1'b0;
                if ($urandom_range(0, 299) == 0) ldHold = $urandom_range(1, 4);
            end
            tick();
        end
        we = 1'b0;
        out_ready = 1'b0;
        settleRun();
        // Drain any leftover words so the abort test starts from a known queue
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) cpuRead(8'd0);
        out_ready = 1'b0;

        // Mid-RUN load request with an in-flight write
        cpuWrite(A_HALT, 16'h0001);
        check("halt_set", 32'(halted), 32'h1);
        cpuWrite(A_OUT_DATA, 16'h0077);
        check("abort_fifo_nonempty", 32'(out_valid), 32'h1);
        ld_en = 1'b1;
        cpuWrite(8'd20, 16'hBEEF);
        check("abort_cpu_rst", 32'(cpu_rst), 32'h1);
        tick();
        check("load_fifo_empty", 32'(out_valid), 32'h0);
        check("load_halt_clear", 32'(halted), 32'h0);
        releaseLoad();
        cpuRead(A_CYC_LO);
        check("cyc_cleared_lo", 32'(dout), 32'h0);
        cpuRead(A_CYC_HI);
        check("cyc_cleared_hi", 32'(dout), 32'h0);

        // HALT freezes the counter at 3
        cpuWrite(A_HALT, 16'h0001);
        cpuRead(8'd0);
        cpuRead(8'd0);
        cpuRead(A_CYC_LO);
        check("halt_frozen_cyc", 32'(dout), 32'd3);
        check("halt_sticky", 32'(halted), 32'h1);

        // Asynchronous reset mid-run keeps RAM contents
        cpuWrite(A_OUT_DATA, 16'h0055);
        cpuRead(8'd20);
        check("inflight_write_kept", 32'(dout), 32'hBEEF);
        rst = 1'b1;
        #1;
        check("async_dout", 32'(dout), 32'h0);
        check("async_cpu_rst", 32'(cpu_rst), 32'h1);
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_halted", 32'(halted), 32'h0);
        modelReset();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("async_release", 32'(cpu_rst), 32'h0);
        cpuRead(8'd20);
        check("ram_survives_rst", 32'(dout), 32'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/tinymips_mem_responder.md
# tinymips_mem_responder

Memory-side responder for the TinyMIPS memory port (wrEn / addr_toRAM / data_toRAM / data_fromRAM). It replaces a bare block RAM with word RAM plus a small memory-mapped I/O window, a host program-load port, and a CPU-reset sequencer. Programs and data are written through the load port instead of by hierarchical memory pokes. The block sits beside the TinyMIPS core at the top level; the core sees the same one-cycle synchronous-read behaviour as a plain RAM.

## Interface
- SIZE, 8: address width in words; total map is 2**SIZE words.
- OUTQ_DEPTH, 4: output FIFO depth (power of two).
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  CPU write enable (driven by core wrEn).
- addr  in  SIZE  CPU word address (core addr_toRAM).
- din  in  16  CPU write data (core data_toRAM).
- dout  out  16  registered read data to core (data_fromRAM).
- cpu_rst  out  1  reset to drive the TinyMIPS rst input.
- ld_en  in  1  host load mode request.
- ld_we  in  1  host write strobe, honoured only while loading.
- ld_addr  in  SIZE  host write address.
- ld_data  in  16  host write data.
- out_valid  out  1  output FIFO non-empty.
- out_data  out  16  output FIFO head word.
- out_ready  in  1  host pops the head when out_valid & out_ready.
- halted  out  1  sticky flag set by a CPU write to HALT.

## Operation
- Address map with top = 2**SIZE. RAM occupies 0 .. top-9. CYC_LO is at top-8; CYC_HI at top-7; OUT_DATA at top-6; OUT_STAT at top-5; HALT at top-4. top-3 .. top-1 read 0 and ignore writes.
- RAM: writes on the clock edge when we=1 and the address is in the RAM range. Reads are read-first: a same-cycle write to the read address returns the old word.
- Sequencer FSM has three states: LOAD, RELEASE, RUN.
  - LOAD: cpu_rst=1; CPU port ignored; ld_we writes ld_data to any RAM address; the cycle counter is cleared, the FIFO is emptied, and halted is cleared. When ld_en=0, go to RELEASE.
  - RELEASE: cpu_rst=1; count 2 cycles, then go to RUN. If ld_en=1, go to LOAD.
  - RUN: cpu_rst=0; CPU port is active. If ld_en=1, go to LOAD; cpu_rst asserts on the next edge.
- Cycle counter: 32 bits, increments every RUN cycle while halted=0, wraps at 2**32-1 to 0.
  - A CPU read of CYC_LO returns the low 16 bits and latches the high 16 bits into a shadow register.
  - A CPU read of CYC_HI returns the shadow.
- OUT_DATA write pushes din into the FIFO.
  - If the FIFO is full with no pop that cycle, the word is dropped and sticky ovf is set.
  - A simultaneous push and pop on a full FIFO is accepted.
  - A read of OUT_DATA returns 0.
- OUT_STAT read layout: bit15 = ovf, bit14 = full, bit13 = empty, bits[7:0] = occupancy. A write of any value to OUT_STAT clears ovf.
- HALT write with din != 0 sets halted. halted holds the counter; the CPU keeps running.
- Arithmetic: FIFO pointers have log2(OUTQ_DEPTH)+1 bits and wrap modulo 2·OUTQ_DEPTH.

## Timing
- Reset values:
  - state = RELEASE with count 0, so cpu_rst=1 for exactly 2 cycles after rst falls unless ld_en=1.
  - dout=0, out_valid=0, out_data=0, halted=0, counter=0, shadow=0, ovf=0.
- Read latency is 1 cycle: the address at edge N gives dout valid after edge N, for both RAM and MMIO.
- The MMIO read side effect (shadow latch) occurs on the same edge that registers dout.
- out_data is combinational from the FIFO head; pop takes effect on the edge.
- LOAD entry is asynchronous-free: sampled on the clock. Mid-RUN ld_en aborts the CPU on the next edge, and in-flight CPU writes that edge are still honoured.
- rst asserted at any time returns everything to reset values immediately. RAM contents are not cleared.

## Structure
- Shared package tinymips_pkg holds:
  - address-offset constants (CYC_LO_OFS=8, CYC_HI_OFS=7, OUT_DATA_OFS=6, OUT_STAT_OFS=5, HALT_OFS=4);
  - the sequencer state encoding;
  - the OUT_STAT bit positions.
- One sub-module, resp_outq: the synchronous FIFO with push/pop/full/empty/count.
- RAM is an inferred array inside the top.

## Test plan
- Reset, then ld_en=0 → cpu_rst high for 2 cycles after rst falls, then low; dout=0.
- LOAD: ld_we writes 0x7205 to addr 0 and 0x0005 to addr 15; release, then CPU read of addr 15 → dout=0x0005 one cycle later. A write of 0x1234 to addr 15 while reading it → dout old 0x0005, next read 0x1234.
- In RUN, wait 100 cycles, then read CYC_LO then CYC_HI → values consistent with ~100 and 0. Force the counter to 0x0000FFFF, then read LO/HI → 0xFFFF/0x0000 even if the counter rolls between the reads.
- Six OUT_DATA writes (1..6) with out_ready=0, depth 4 → occupancy 4, ovf=1, FIFO pops 1,2,3,4. An OUT_STAT write clears ovf.
- Full FIFO with push and pop in the same cycle → occupancy stays 4 and ovf stays 0.
- ld_en asserted mid-RUN → cpu_rst=1 next edge, counter 0, FIFO empty, halted cleared. HALT write of 1 → halted=1 and counter frozen.
